// File: rtl/raster_ray_fifo_pkg.sv
// Shared ray types passed from the raster ray generator to traversal,
// plus the default depth of the ray FIFO between them.
package raster_ray_fifo_pkg;

  localparam int COORD_W        = 16;
  localparam int PIXEL_W        = 16;
  localparam int RAY_FIFO_DEPTH = 4;

  typedef struct packed {
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
    logic signed [COORD_W-1:0] z;
  } vec3_t;

  // Direction and its per-axis reciprocal travel together so traversal never divides.
  typedef struct packed {
    vec3_t Dir;
    vec3_t InvDir;
  } RasterRay;

  typedef struct packed {
    logic               is_reflection;
    logic [PIXEL_W-1:0] pixel_id;
    RasterRay           ray;
  } RasterInputData;

endpackage

// File: rtl/ray_fifo_mem.sv
// Ray storage for the FIFO: one synchronous write port, one asynchronous read port,
// zero latency on read; only entry 0 is reset so the empty FIFO presents all-zero data.
module ray_fifo_mem
  import raster_ray_fifo_pkg::*;
#(
  parameter int DEPTH = RAY_FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  RasterInputData wdata,
  input  logic [AW-1:0]  raddr,
  output RasterInputData rdata
);

  RasterInputData entry0;
  RasterInputData mem_hi [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      entry0 <= '0;
    end else if (we && (waddr == '0)) begin
      entry0 <= wdata;
    end
  end

  // Element 0 of mem_hi is never used; entry0 holds that slot with a reset.
  always_ff @(posedge clk) begin
    if (we && (waddr != '0)) begin
      mem_hi[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = mem_hi[raddr];
    if (raddr == '0) begin
      rdata = entry0;
    end
  end

endmodule

// File: rtl/raster_ray_fifo.sv
// Ray FIFO between generator and traversal; push visible one edge later, no fall-through.
// fifo_full is decoded from count alone, leaving SKID slots for the generator's late push.
module raster_ray_fifo
  import raster_ray_fifo_pkg::*;
#(
  parameter int DEPTH = RAY_FIFO_DEPTH,
  parameter int SKID  = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  input  RasterInputData         in_data,
  output logic                   fifo_full,
  output logic                   out_valid,
  output RasterInputData         out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0] HIGH_WATER = CW'(DEPTH - SKID);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SKID < 1 || SKID >= DEPTH) begin : g_bad_param
    $error("raster_ray_fifo: DEPTH must be a power of two >= 2 and 1 <= SKID < DEPTH");
  end

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push;
  logic          pop;
  logic          drop;

  always_comb begin
    pop  = out_valid && out_ready;
    push = in_valid && ((count != FULL_CNT) || pop);
    drop = in_valid && !push;
  end

  // Pointers wrap by natural overflow; full vs empty is told apart by count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  assign out_valid = (count != '0);
  assign fifo_full = (count >= HIGH_WATER);

  ray_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk    (clk),
    .resetn (resetn),
    .we     (push),
    .waddr  (wptr),
    .wdata  (in_data),
    .raddr  (rptr),
    .rdata  (out_data)
  );

endmodule

// File: tb/tb_raster_ray_fifo.sv
// Directed bench for raster_ray_fifo at DEPTH=4, SKID=1, ending with a generator-model soak.
module tb_raster_ray_fifo;
  import raster_ray_fifo_pkg::*;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           in_valid = 1'b0;
  RasterInputData in_data = '0;
  logic           fifo_full;
  logic           out_valid;
  RasterInputData out_data;
  logic           out_ready = 1'b0;
  logic [2:0]     count;
  logic           overflow;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  raster_ray_fifo #(
    .DEPTH (4),
    .SKID  (1)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .fifo_full (fifo_full),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow)
  );

  function automatic RasterInputData make_ray(input logic [15:0] x);
    RasterInputData r;
    r = '0;
    r.ray.Dir.x     = x;
    r.ray.Dir.y     = x ^ 16'h5a5a;
    r.ray.InvDir.z  = ~x;
    r.pixel_id      = x + 16'd7;
    r.is_reflection = x[0];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] x);
    in_valid = 1'b1;
    in_data  = make_ray(x);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int  sent;
    int  recv;
    bit  fire;
    bit  saw_full;

    // Power-on reset
    #12;
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_fifo_full", 128'(fifo_full), 128'(0));
    chk("rst_overflow", 128'(overflow), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    resetn = 1'b1;
    step();

    // Fill to high water, then to DEPTH
    out_ready = 1'b0;
    push(16'd1);
    chk("fill1_count", 128'(count), 128'(1));
    chk("fill1_out_valid", 128'(out_valid), 128'(1));
    chk("fill1_head", 128'(out_data), 128'(make_ray(16'd1)));
    push(16'd2);
    chk("fill2_full", 128'(fifo_full), 128'(0));
    push(16'd3);
    chk("fill3_count", 128'(count), 128'(3));
    chk("fill3_full", 128'(fifo_full), 128'(1));
    push(16'd4);
    chk("fill4_count", 128'(count), 128'(4));
    chk("fill4_overflow", 128'(overflow), 128'(0));

    // Overflow drop
    push(16'd5);
    chk("ovf_count", 128'(count), 128'(4));
    chk("ovf_flag", 128'(overflow), 128'(1));

    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", 128'(out_data), 128'(make_ray(16'(i))));
      step();
      chk("drain_count", 128'(count), 128'(4 - i));
      chk("drain_full", 128'(fifo_full), 128'((4 - i) >= 3));
    end
    chk("drain_empty", 128'(out_valid), 128'(0));
    chk("ovf_sticky", 128'(overflow), 128'(1));
    out_ready = 1'b0;

    // Asynchronous reset mid-stream
    push(16'd10);
    push(16'd11);
    push(16'd12);
    chk("mid_count", 128'(count), 128'(3));
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_count", 128'(count), 128'(0));
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_fifo_full", 128'(fifo_full), 128'(0));
    chk("arst_overflow", 128'(overflow), 128'(0));
    chk("arst_out_data", 128'(out_data), 128'(0));
    step();
    resetn = 1'b1;
    push(16'd20);
    chk("post_rst_head", 128'(out_data), 128'(make_ray(16'd20)));
    push(16'd21);
    push(16'd22);
    push(16'd23);
    chk("full_again_count", 128'(count), 128'(4));

    // Simultaneous push and pop at full
    in_valid  = 1'b1;
    in_data   = make_ray(16'd24);
    out_ready = 1'b1;
    chk("simul_head_pre", 128'(out_data), 128'(make_ray(16'd20)));
    step();
    in_valid = 1'b0;
    chk("simul_count", 128'(count), 128'(4));
    chk("simul_overflow", 128'(overflow), 128'(0));
    for (int j = 21; j <= 24; j++) begin
      chk("simul_drain", 128'(out_data), 128'(make_ray(16'(j))));
      step();
    end
    chk("simul_empty", 128'(count), 128'(0));

    // Streaming push+pop with pointer wrap
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_data  = make_ray(16'(100 + k));
      if (k > 0) begin
        chk("stream_data", 128'(out_data), 128'(make_ray(16'(99 + k))));
      end
      step();
      chk("stream_count", 128'(count), 128'(1));
    end
    in_valid = 1'b0;
    chk("stream_last", 128'(out_data), 128'(make_ray(16'd119)));
    step();
    chk("stream_end_count", 128'(count), 128'(0));

    // Generator model: valid one cycle after fifo_full sampled low
    sent = 0;
    recv = 0;
    fire = 1'b0;
    saw_full = 1'b0;
    for (int cyc = 0; cyc < 20000 && recv < 1000; cyc++) begin
      if (((cyc / 50) % 2) == 1) out_ready = ($urandom_range(0, 4) == 0);
      else                       out_ready = ($urandom_range(0, 1) == 0);
      if (fifo_full) saw_full = 1'b1;
      if (out_valid && out_ready) begin
        chk("gen_order", 128'(out_data), 128'(make_ray(16'(recv))));
        recv++;
      end
      in_valid = fire;
      if (fire) begin
        in_data = make_ray(16'(sent));
        sent++;
      end
      fire = !fire && !fifo_full && (sent < 1000) && ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    chk("gen_delivered", 128'(recv), 128'(1000));
    chk("gen_overflow", 128'(overflow), 128'(0));
    chk("gen_saw_full", 128'(saw_full), 128'(1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule
